// File: rtl/mod_writeback_pkg.sv
// -----------------------------------------------------------------------------
// mod_writeback_pkg
// Shared types and constants for the writeback stage and its register file.
//   flags_reg   : RFLAGS layout (64 bits, only the low 12 bits architected)
//   MEM_EX      : instruction bundle captured from execute on a transfer
//   wb_state_e  : writeback sequencing states
//   OP_IMUL     : opcode of the two-result multiply (RAX + RDX)
//   REG_RAX/RDX : fixed destinations used by IMUL
// Optional build macro consumed by users of this package: WB_BYPASS_EN.
// -----------------------------------------------------------------------------
package mod_writeback_pkg;

    localparam int NUM_REGS = 16;

    typedef struct packed {
        logic [51:0] res_hi;
        logic        of_f;
        logic        df_f;
        logic        if_f;
        logic        tf_f;
        logic        sf_f;
        logic        zf_f;
        logic        res_5;
        logic        af_f;
        logic        res_3;
        logic        pf_f;
        logic        res_1;
        logic        cf_f;
    } flags_reg;

    // Only the always-one reserved bit is set out of reset.
    localparam flags_reg FLAGS_RESET = flags_reg'(64'h2);

    localparam logic [7:0] OP_IMUL = 8'd247;

    localparam logic [3:0] REG_RAX = 4'd0;
    localparam logic [3:0] REG_RDX = 4'd2;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [1:0]  dep;
        logic [3:0]  reg_byte;
        logic [3:0]  rm_byte;
        logic        sim_end;
        logic        wen;
        logic [63:0] alu_result;
        logic [63:0] alu_ext_result;
        logic [63:0] rip;
        flags_reg    flags;
        logic        flags_we;
    } MEM_EX;

    typedef enum logic [1:0] {
        WB_IDLE     = 2'd0,
        WB_WRITE    = 2'd1,
        WB_WRITE_HI = 2'd2,
        WB_DONE     = 2'd3
    } wb_state_e;

    // An IMUL only needs the RDX cycle when it actually writes registers.
    function automatic logic needs_write_hi(input MEM_EX m);
        return (m.opcode == OP_IMUL) && m.wen;
    endfunction

    // dep==2 means the ModRM reg field names the destination.
    function automatic logic [3:0] dest_reg(input MEM_EX m);
        return (m.dep == 2'd2) ? m.reg_byte : m.rm_byte;
    endfunction

endpackage

// File: rtl/mod_writeback_if.sv
// -----------------------------------------------------------------------------
// mod_writeback_if
// Execute -> writeback handshake bundle.
//   ex_valid / wb_ready : transfer when both are high at a rising edge
//   ex_*                : instruction control, results, PC and flags
// Modports: master = execute side (drives ex_*), slave = writeback side.
// -----------------------------------------------------------------------------
interface mod_writeback_if;
    import mod_writeback_pkg::*;

    logic        ex_valid;
    logic        wb_ready;
    logic        ex_wen;
    logic [7:0]  ex_opcode;
    logic [1:0]  ex_dep;
    logic [3:0]  ex_regByte;
    logic [3:0]  ex_rmByte;
    logic        ex_sim_end;
    logic [63:0] ex_alu_result;
    logic [63:0] ex_alu_ext_result;
    logic [63:0] ex_rip;
    flags_reg    ex_flags;
    logic        ex_flags_we;

    modport master (
        output ex_valid, ex_wen, ex_opcode, ex_dep, ex_regByte, ex_rmByte,
               ex_sim_end, ex_alu_result, ex_alu_ext_result, ex_rip,
               ex_flags, ex_flags_we,
        input  wb_ready
    );

    modport slave (
        input  ex_valid, ex_wen, ex_opcode, ex_dep, ex_regByte, ex_rmByte,
               ex_sim_end, ex_alu_result, ex_alu_ext_result, ex_rip,
               ex_flags, ex_flags_we,
        output wb_ready
    );

endinterface

// File: rtl/mod_writeback_regfile.sv
// -----------------------------------------------------------------------------
// mod_regfile
// 16 x 64-bit architectural register file, one write port, two combinational
// read ports.
//   clk, reset_n        : clock, synchronous active-low reset (clears all regs)
//   we, waddr, wdata    : write port, committed on the rising edge
//   rd_addr_a/b         : read addresses
//   rd_data_a/b         : read data
// Build macro WB_BYPASS_EN: when defined, a read that hits the register being
// written this cycle returns the write data; otherwise it returns the stored
// value and decode is expected to stall on the dependency.
// -----------------------------------------------------------------------------
module mod_regfile
    import mod_writeback_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        we,
    input  logic [3:0]  waddr,
    input  logic [63:0] wdata,
    input  logic [3:0]  rd_addr_a,
    input  logic [3:0]  rd_addr_b,
    output logic [63:0] rd_data_a,
    output logic [63:0] rd_data_b
);

    logic [63:0] mem_q [NUM_REGS];
    logic [63:0] mem_d [NUM_REGS];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= 64'd0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
`ifdef WB_BYPASS_EN
        rd_data_a = (we && (waddr == rd_addr_a)) ? wdata : mem_q[rd_addr_a];
        rd_data_b = (we && (waddr == rd_addr_b)) ? wdata : mem_q[rd_addr_b];
`else
        rd_data_a = mem_q[rd_addr_a];
        rd_data_b = mem_q[rd_addr_b];
`endif
    end

endmodule

// File: rtl/mod_writeback.sv
// -----------------------------------------------------------------------------
// mod_writeback
// Writeback stage: captures a completed instruction from execute, writes its
// result(s) into the register file, updates RFLAGS and retirement state.
//   clk, reset_n             : clock, synchronous active-low reset
//   ex (slave)               : execute handshake and instruction bundle
//   rd_addr_a/b, rd_data_a/b : register-file read ports for decode
//   rflags_seq               : architectural flags
//   retired_count/rip        : retired-instruction count and last retired PC
//   sim_done                 : sticky, the sim_end instruction has retired
// Build macro WB_BYPASS_EN enables write-to-read bypass in mod_regfile.
// -----------------------------------------------------------------------------
module mod_writeback
    import mod_writeback_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    mod_writeback_if.slave  ex,
    input  logic [3:0]      rd_addr_a,
    input  logic [3:0]      rd_addr_b,
    output logic [63:0]     rd_data_a,
    output logic [63:0]     rd_data_b,
    output flags_reg        rflags_seq,
    output logic [63:0]     retired_count,
    output logic [63:0]     retired_rip,
    output logic            sim_done
);

    wb_state_e   state_q, state_d;
    MEM_EX       wb_q, wb_d;
    flags_reg    rflags_q, rflags_d;
    logic [63:0] retired_count_q, retired_count_d;
    logic [63:0] retired_rip_q, retired_rip_d;
    logic        sim_done_q, sim_done_d;

    logic        wb_ready;
    logic        transfer;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [63:0] rf_wdata;

    // A WRITE cycle can overlap the next transfer only if it is the last
    // cycle of its instruction and does not end the simulation.
    always_comb begin
        wb_ready = 1'b0;
        case (state_q)
            WB_IDLE:  wb_ready = 1'b1;
            WB_WRITE: wb_ready = !(needs_write_hi(wb_q) || wb_q.sim_end);
            default:  wb_ready = 1'b0;
        endcase
        if (!reset_n) begin
            wb_ready = 1'b0;
        end
    end

    assign ex.wb_ready = wb_ready;
    assign transfer    = ex.ex_valid && wb_ready;

    always_comb begin
        state_d         = state_q;
        wb_d            = wb_q;
        rflags_d        = rflags_q;
        retired_count_d = retired_count_q;
        retired_rip_d   = retired_rip_q;
        sim_done_d      = sim_done_q;
        rf_we           = 1'b0;
        rf_waddr        = 4'd0;
        rf_wdata        = 64'd0;

        if (transfer) begin
            wb_d.opcode         = ex.ex_opcode;
            wb_d.dep            = ex.ex_dep;
            wb_d.reg_byte       = ex.ex_regByte;
            wb_d.rm_byte        = ex.ex_rmByte;
            wb_d.sim_end        = ex.ex_sim_end;
            wb_d.wen            = ex.ex_wen;
            wb_d.alu_result     = ex.ex_alu_result;
            wb_d.alu_ext_result = ex.ex_alu_ext_result;
            wb_d.rip            = ex.ex_rip;
            wb_d.flags          = ex.ex_flags;
            wb_d.flags_we       = ex.ex_flags_we;
        end

        case (state_q)
            WB_IDLE: begin
                if (transfer) begin
                    state_d = WB_WRITE;
                end
            end

            WB_WRITE: begin
                if (wb_q.wen) begin
                    rf_we    = 1'b1;
                    rf_waddr = needs_write_hi(wb_q) ? REG_RAX : dest_reg(wb_q);
                    rf_wdata = wb_q.alu_result;
                end
                if (wb_q.flags_we) begin
                    rflags_d = wb_q.flags;
                end
                if (needs_write_hi(wb_q)) begin
                    state_d = WB_WRITE_HI;
                end else begin
                    retired_count_d = retired_count_q + 64'd1;
                    retired_rip_d   = wb_q.rip;
                    if (wb_q.sim_end) begin
                        state_d    = WB_DONE;
                        sim_done_d = 1'b1;
                    end else if (transfer) begin
                        state_d = WB_WRITE;
                    end else begin
                        state_d = WB_IDLE;
                    end
                end
            end

            WB_WRITE_HI: begin
                rf_we           = 1'b1;
                rf_waddr        = REG_RDX;
                rf_wdata        = wb_q.alu_ext_result;
                retired_count_d = retired_count_q + 64'd1;
                retired_rip_d   = wb_q.rip;
                if (wb_q.sim_end) begin
                    state_d    = WB_DONE;
                    sim_done_d = 1'b1;
                end else begin
                    state_d = WB_IDLE;
                end
            end

            WB_DONE: begin
                state_d = WB_DONE;
            end

            default: begin
                state_d = WB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q         <= WB_IDLE;
            rflags_q        <= FLAGS_RESET;
            retired_count_q <= 64'd0;
            retired_rip_q   <= 64'd0;
            sim_done_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            rflags_q        <= rflags_d;
            retired_count_q <= retired_count_d;
            retired_rip_q   <= retired_rip_d;
            sim_done_q      <= sim_done_d;
        end
    end

    // The captured bundle is only consulted in WRITE/WRITE_HI, which are
    // always entered through a transfer, so it needs no reset.
    always_ff @(posedge clk) begin
        wb_q <= wb_d;
    end

    assign rflags_seq    = rflags_q;
    assign retired_count = retired_count_q;
    assign retired_rip   = retired_rip_q;
    assign sim_done      = sim_done_q;

    mod_regfile u_regfile (
        .clk       (clk),
        .reset_n   (reset_n),
        .we        (rf_we),
        .waddr     (rf_waddr),
        .wdata     (rf_wdata),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b)
    );

endmodule

// File: tb/tb_mod_writeback.sv
// -----------------------------------------------------------------------------
// tb_mod_writeback
// Directed bench for mod_writeback. A transaction-level model schedules the
// architectural effects of each accepted instruction at the edge where they
// must become visible; a negedge process compares every DUT output against
// it, and the directed sequence adds literal expectations.
// Honours WB_BYPASS_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_mod_writeback;
    import mod_writeback_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  rd_addr_a = 4'd0;
    logic [3:0]  rd_addr_b = 4'd0;
    logic [63:0] rd_data_a, rd_data_b;
    flags_reg    rflags_seq;
    logic [63:0] retired_count, retired_rip;
    logic        sim_done;

    mod_writeback_if ex_if ();

    mod_writeback dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ex            (ex_if),
        .rd_addr_a     (rd_addr_a),
        .rd_addr_b     (rd_addr_b),
        .rd_data_a     (rd_data_a),
        .rd_data_b     (rd_data_b),
        .rflags_seq    (rflags_seq),
        .retired_count (retired_count),
        .retired_rip   (retired_rip),
        .sim_done      (sim_done)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    localparam int K_WR    = 0;
    localparam int K_FLAGS = 1;
    localparam int K_RET   = 2;
    localparam int K_DONE  = 3;

    typedef struct {
        int          edge_n;
        int          kind;
        logic [3:0]  addr;
        logic [63:0] data;
    } act_t;

    act_t        pend[$];
    logic [63:0] m_regs [16];
    logic [63:0] m_flags = 64'h2;
    logic [63:0] m_count = 64'd0;
    logic [63:0] m_rip   = 64'd0;
    bit          m_done  = 1'b0;
    int          ecount  = 0;
    int          stall_until = 0;

    function automatic act_t mk(input int e, input int k, input logic [3:0] a, input logic [63:0] d);
        act_t x;
        x.edge_n = e; x.kind = k; x.addr = a; x.data = d;
        return x;
    endfunction

    always @(posedge clk) begin
        bit   ready_prev;
        bit   imul2;
        int   fin;
        act_t keep[$];
        ecount++;
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) m_regs[i] = 64'd0;
            m_flags = 64'h2;
            m_count = 64'd0;
            m_rip   = 64'd0;
            m_done  = 1'b0;
            pend.delete();
            stall_until = ecount;
        end else begin
            ready_prev = !m_done && ((ecount - 1) >= stall_until);
            keep.delete();
            foreach (pend[i]) begin
                if (pend[i].edge_n == ecount) begin
                    case (pend[i].kind)
                        K_WR:    m_regs[pend[i].addr] = pend[i].data;
                        K_FLAGS: m_flags = pend[i].data;
                        K_RET:   begin m_count = m_count + 64'd1; m_rip = pend[i].data; end
                        default: m_done = 1'b1;
                    endcase
                end else begin
                    keep.push_back(pend[i]);
                end
            end
            pend = keep;
            if (ex_if.ex_valid && ready_prev) begin
                imul2 = (ex_if.ex_opcode == 8'd247) && ex_if.ex_wen;
                fin   = ecount + (imul2 ? 2 : 1);
                if (ex_if.ex_wen)
                    pend.push_back(mk(ecount + 1, K_WR,
                        imul2 ? 4'd0 : ((ex_if.ex_dep == 2'd2) ? ex_if.ex_regByte : ex_if.ex_rmByte),
                        ex_if.ex_alu_result));
                if (imul2)
                    pend.push_back(mk(ecount + 2, K_WR, 4'd2, ex_if.ex_alu_ext_result));
                if (ex_if.ex_flags_we)
                    pend.push_back(mk(ecount + 1, K_FLAGS, 4'd0, 64'(ex_if.ex_flags)));
                pend.push_back(mk(fin, K_RET, 4'd0, ex_if.ex_rip));
                if (ex_if.ex_sim_end) begin
                    pend.push_back(mk(fin, K_DONE, 4'd0, 64'd0));
                    stall_until = 32'h3fff_ffff;
                end else begin
                    stall_until = imul2 ? ecount + 2 : ecount;
                end
            end
        end
    end

    function automatic logic [63:0] rd_expect(input logic [3:0] a);
        logic [63:0] v;
        v = m_regs[a];
`ifdef WB_BYPASS_EN
        foreach (pend[i])
            if (pend[i].edge_n == ecount + 1 && pend[i].kind == K_WR && pend[i].addr == a)
                v = pend[i].data;
`endif
        return v;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_wb_ready", 64'(ex_if.wb_ready),
                  64'(reset_n && !m_done && (ecount >= stall_until)));
            check("cyc_retired_count", retired_count, m_count);
            check("cyc_retired_rip", retired_rip, m_rip);
            check("cyc_sim_done", 64'(sim_done), 64'(m_done));
            check("cyc_rflags", 64'(rflags_seq), m_flags);
            check("cyc_rd_data_a", rd_data_a, rd_expect(rd_addr_a));
            check("cyc_rd_data_b", rd_data_b, rd_expect(rd_addr_b));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [7:0] op, input logic [1:0] dep,
                         input logic [3:0] rb, input logic [3:0] rm,
                         input logic wen, input logic send,
                         input logic [63:0] res, input logic [63:0] ext,
                         input logic [63:0] rip, input logic [63:0] flg,
                         input logic fwe);
        ex_if.ex_valid          = 1'b1;
        ex_if.ex_opcode         = op;
        ex_if.ex_dep            = dep;
        ex_if.ex_regByte        = rb;
        ex_if.ex_rmByte         = rm;
        ex_if.ex_wen            = wen;
        ex_if.ex_sim_end        = send;
        ex_if.ex_alu_result     = res;
        ex_if.ex_alu_ext_result = ext;
        ex_if.ex_rip            = rip;
        ex_if.ex_flags          = flags_reg'(flg);
        ex_if.ex_flags_we       = fwe;
    endtask

    task automatic idle();
        ex_if.ex_valid = 1'b0;
    endtask

    initial begin
        drive(8'd0, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0);
        idle();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        chk_en  = 1'b1;
        #1;
        check("reset_count", retired_count, 64'd0);
        check("reset_rflags", 64'(rflags_seq), 64'h2);
        check("reset_sim_done", 64'(sim_done), 64'd0);

        // Single write: opcode 199, dep=0, rm=3
        tick();
        drive(8'd199, 2'd0, 4'd7, 4'd3, 1'b1, 1'b0, 64'h1234, 64'd0, 64'h1000, 64'h46, 1'b1);
        tick();
        idle();
        #1 check("single_ready_in_write", 64'(ex_if.wb_ready), 64'd1);
        tick();
        rd_addr_a = 4'd3;
        #1;
        check("single_reg3", rd_data_a, 64'h1234);
        check("single_count", retired_count, 64'd1);
        check("single_rip", retired_rip, 64'h1000);
        check("single_flags", 64'(rflags_seq), 64'h46);
        check("model_reg3", m_regs[3], 64'h1234);

        // IMUL: RAX at edge 1, RDX at edge 2
        tick();
        drive(8'd247, 2'd0, 4'd1, 4'd1, 1'b1, 1'b0, 64'hA, 64'hB, 64'h2000, 64'd0, 1'b0);
        tick();
        idle();
        #1 check("imul_ready_write", 64'(ex_if.wb_ready), 64'd0);
        tick();
        rd_addr_a = 4'd0;
        rd_addr_b = 4'd2;
        #1;
        check("imul_rax", rd_data_a, 64'hA);
        check("imul_ready_write_hi", 64'(ex_if.wb_ready), 64'd0);
        check("imul_count_mid", retired_count, 64'd1);
`ifdef WB_BYPASS_EN
        check("imul_rdx_bypass", rd_data_b, 64'hB);
`else
        check("imul_rdx_old", rd_data_b, 64'd0);
`endif
        tick();
        #1;
        check("imul_rdx", rd_data_b, 64'hB);
        check("imul_count", retired_count, 64'd2);
        check("imul_ready_after", 64'(ex_if.wb_ready), 64'd1);
        check("model_count_imul", m_count, 64'd2);

        // Conditional jump: no register or flag change
        drive(8'd116, 2'd0, 4'd3, 4'd3, 1'b0, 1'b0, 64'hDEAD, 64'd0, 64'h3000, 64'hFFF, 1'b0);
        tick();
        idle();
        tick();
        rd_addr_a = 4'd3;
        #1;
        check("jcc_reg3", rd_data_a, 64'h1234);
        check("jcc_flags", 64'(rflags_seq), 64'h46);
        check("jcc_count", retired_count, 64'd3);
        check("jcc_rip", retired_rip, 64'h3000);

        // Back-to-back writes to reg5 (dep=2 selects regByte), read during 2nd write
        drive(8'd199, 2'd2, 4'd5, 4'd9, 1'b1, 1'b0, 64'h55, 64'd0, 64'h3100, 64'd0, 1'b0);
        tick();
        drive(8'd199, 2'd2, 4'd5, 4'd9, 1'b1, 1'b0, 64'hFF, 64'd0, 64'h3104, 64'd0, 1'b0);
        tick();
        idle();
        rd_addr_a = 4'd5;
        rd_addr_b = 4'd9;
        #1;
`ifdef WB_BYPASS_EN
        check("bypass_reg5", rd_data_a, 64'hFF);
`else
        check("nobypass_reg5", rd_data_a, 64'h55);
`endif
        check("dep2_reg9_untouched", rd_data_b, 64'd0);
        tick();
        #1;
        check("b2b_reg5", rd_data_a, 64'hFF);
        check("b2b_count", retired_count, 64'd5);
        check("b2b_rip", retired_rip, 64'h3104);

        // Reset during WRITE_HI abandons the IMUL
        drive(8'd247, 2'd0, 4'd0, 4'd0, 1'b1, 1'b0, 64'h11, 64'h77, 64'h5000, 64'd0, 1'b0);
        tick();
        idle();
        tick();
        reset_n = 1'b0;
        #1 check("reset_cycle_ready", 64'(ex_if.wb_ready), 64'd0);
        tick();
        reset_n = 1'b1;
        rd_addr_a = 4'd0;
        rd_addr_b = 4'd2;
        #1;
        check("rst_imul_rdx", rd_data_b, 64'd0);
        check("rst_imul_rax", rd_data_a, 64'd0);
        check("rst_imul_count", retired_count, 64'd0);
        check("rst_imul_rip", retired_rip, 64'd0);
        check("rst_imul_idle_ready", 64'(ex_if.wb_ready), 64'd1);

        // sim_end on the second of two back-to-back transfers
        drive(8'd199, 2'd0, 4'd0, 4'd4, 1'b1, 1'b0, 64'h44, 64'd0, 64'h4000, 64'd0, 1'b0);
        tick();
        drive(8'd199, 2'd0, 4'd0, 4'd6, 1'b1, 1'b1, 64'h66, 64'd0, 64'h4004, 64'd0, 1'b0);
        tick();
        drive(8'd199, 2'd0, 4'd0, 4'd8, 1'b1, 1'b0, 64'h88, 64'd0, 64'h4008, 64'd0, 1'b0);
        #1 check("send_ready_write", 64'(ex_if.wb_ready), 64'd0);
        for (int i = 0; i < 4; i++) tick();
        rd_addr_a = 4'd4;
        rd_addr_b = 4'd6;
        #1;
        check("send_reg4", rd_data_a, 64'h44);
        check("send_reg6", rd_data_b, 64'h66);
        check("send_count", retired_count, 64'd2);
        check("send_rip", retired_rip, 64'h4004);
        check("send_done", 64'(sim_done), 64'd1);
        check("send_ready_done", 64'(ex_if.wb_ready), 64'd0);
        rd_addr_a = 4'd8;
        #1;
        check("send_reg8_ignored", rd_data_a, 64'd0);
        check("model_done", 64'(m_done), 64'd1);
        idle();
        tick();
        tick();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
